// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder driving one full_adder cell LSB first,
// presenting {cout,sum} = a + b + cin with a one-cycle done pulse.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic sum,
   output logic cout
);
   assign sum  = A ^ B ^ C;
   assign cout = (A & B) | (C & (A ^ B));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nx;
   logic [CW-1:0]    cnt;
   logic             carry, fa_sum, fa_cout, last;
   full_adder u_fa (
      .A    (a_sh[0]),
      .B    (b_sh[0]),
      .C    (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );
   assign last = cnt == CW'(WIDTH - 1);
   // shift the new sum bit in at the MSB; written without slicing so WIDTH=1 works
   assign r_nx = (r_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      state_nx = state == IDLE ? (start ? RUN : IDLE) :
                 state == RUN  ? (last ? DONE : RUN)  : IDLE;
   end
   always_comb begin
      busy = state == RUN;
      done = state == DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         r_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (state == IDLE && start) begin
         a_sh  <= a;
         b_sh  <= b;
         r_sh  <= '0;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         r_sh  <= r_nx;
         carry <= fa_cout;
         cnt   <= cnt + CW'(1);
         if (last) begin
            sum  <= r_nx;
            cout <= fa_cout;
         end
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for WIDTH=8 directed/random plus
// exhaustive WIDTH=3 and WIDTH=1 instances.
module tb_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst8_n = 1'b0, rst_s_n = 1'b0;
   int   cyc = 0, tests = 0, fails = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   logic       start3 = 1'b0, cin3 = 1'b0, busy3, done3, cout3;
   logic [2:0] a3 = '0, b3 = '0, sum3;
   logic       start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
   logic [0:0] a1 = '0, b1 = '0, sum1;
   logic [8:0] exp8[$];
   logic [3:0] exp3[$];
   logic [1:0] exp1[$];
   bit         fin3 = 1'b0, fin1 = 1'b0;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .start(start8), .a(a8), .b(b8),
      .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
   serial_adder_ctrl #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_s_n), .start(start3), .a(a3), .b(b3),
      .cin(cin3), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3));
   serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_s_n), .start(start1), .a(a1), .b(b1),
      .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

   // WIDTH=8 monitor: result, hold, busy length, exclusivity and spacing checks
   logic [8:0] prev8 = '0, e8;
   int         last8 = -1, blen8 = 0;
   always @(negedge clk) begin
      if (!rst8_n) begin
         last8 = -1;
         blen8 = 0;
      end else begin
         tests++;
         if (busy8 && done8) begin
            fails++;
            $display("FAIL excl8 busy=%0b done=%0b required not both", busy8, done8);
         end
         if (busy8) blen8++;
         else if (blen8 != 0) begin
            tests++;
            if (blen8 != 8) begin
               fails++;
               $display("FAIL busylen8 got %0d required 8", blen8);
            end
            blen8 = 0;
         end
         if (done8) begin
            tests++;
            if (exp8.size() == 0) begin
               fails++;
               $display("FAIL unexpected8 done with {cout,sum}=%h required no done", {cout8, sum8});
            end else begin
               e8 = exp8.pop_front();
               if ({cout8, sum8} !== e8) begin
                  fails++;
                  $display("FAIL result8 got %h required %h", {cout8, sum8}, e8);
               end
            end
            if (last8 >= 0) begin
               tests++;
               if (cyc - last8 < 10) begin
                  fails++;
                  $display("FAIL spacing8 got %0d required >=10", cyc - last8);
               end
            end
            last8 = cyc;
         end else if ({cout8, sum8} !== prev8) begin
            fails++;
            $display("FAIL hold8 got %h required %h", {cout8, sum8}, prev8);
         end
      end
      prev8 = {cout8, sum8};
   end

   logic [3:0] e3;
   int         last3 = -1;
   always @(negedge clk) if (rst_s_n && done3) begin
      tests++;
      if (exp3.size() == 0) begin
         fails++;
         $display("FAIL unexpected3 got %h required no done", {cout3, sum3});
      end else begin
         e3 = exp3.pop_front();
         if ({cout3, sum3} !== e3) begin
            fails++;
            $display("FAIL result3 got %h required %h", {cout3, sum3}, e3);
         end
      end
      if (last3 >= 0 && cyc - last3 < 5) begin
         fails++;
         $display("FAIL spacing3 got %0d required >=5", cyc - last3);
      end
      last3 = cyc;
   end

   logic [1:0] e1;
   int         last1 = -1;
   always @(negedge clk) if (rst_s_n && done1) begin
      tests++;
      if (exp1.size() == 0) begin
         fails++;
         $display("FAIL unexpected1 got %h required no done", {cout1, sum1});
      end else begin
         e1 = exp1.pop_front();
         if ({cout1, sum1} !== e1) begin
            fails++;
            $display("FAIL result1 got %h required %h", {cout1, sum1}, e1);
         end
      end
      if (last1 >= 0 && cyc - last1 < 3) begin
         fails++;
         $display("FAIL spacing1 got %0d required >=3", cyc - last1);
      end
      last1 = cyc;
   end

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] e);
      int n = 0;
      while ((busy8 || done8) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy8 || done8) begin
         tests++;
         fails++;
         $display("FAIL idle8 busy=%0b done=%0b required idle", busy8, done8);
      end
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      exp8.push_back(e);
      @(posedge clk); #1;
      start8 = 1'b0;
   endtask

   task automatic wait_done8(output int t);
      int n = 0;
      while (!done8 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done8) begin
         tests++;
         fails++;
         $display("FAIL timeout8 done=%0b required 1", done8);
      end
      t = cyc;
      @(posedge clk); #1;
   endtask

   initial begin
      int t1, t2, n;
      logic [7:0] ra, rb;
      logic       rc;
      #2;
      tests++;
      if ({busy8, done8, cout8, sum8} !== 11'd0) begin
         fails++;
         $display("FAIL reset8 got %h required 000", {busy8, done8, cout8, sum8});
      end
      #20 rst8_n = 1'b1; rst_s_n = 1'b1;
      @(posedge clk); #1;
      op8(8'h00, 8'h00, 1'b0, 9'h000);
      op8(8'hFF, 8'h01, 1'b0, 9'h100);
      op8(8'h7F, 8'h01, 1'b0, 9'h080);
      op8(8'hA5, 8'h5A, 1'b1, 9'h100);
      op8(8'h12, 8'h34, 1'b1, 9'h047);
      // request while busy must be ignored; holding start chains the next op
      op8(8'h0F, 8'h01, 1'b0, 9'h010);
      repeat (2) @(posedge clk);
      #1;
      a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      exp8.push_back(9'h1FE);
      wait_done8(t1);
      repeat (3) @(posedge clk);
      #1 start8 = 1'b0;
      wait_done8(t2);
      tests++;
      if (t2 - t1 != 10) begin
         fails++;
         $display("FAIL backtoback8 spacing got %0d required 10", t2 - t1);
      end
      // asynchronous reset mid-operation
      op8(8'hFF, 8'hFF, 1'b0, 9'h1FE);
      repeat (4) @(posedge clk);
      #3 rst8_n = 1'b0;
      #1;
      tests++;
      if ({busy8, done8, cout8, sum8} !== 11'd0) begin
         fails++;
         $display("FAIL asyncrst8 got %h required 000", {busy8, done8, cout8, sum8});
      end
      exp8.delete();
      repeat (3) @(posedge clk);
      #3 rst8_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      op8(8'h03, 8'h04, 1'b0, 9'h007);
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         op8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      end
      n = 0;
      while ((exp8.size() != 0 || !fin3 || !fin1 || exp3.size() != 0 || exp1.size() != 0) && n < 2000) begin
         @(posedge clk);
         n++;
      end
      tests++;
      if (exp8.size() != 0 || exp3.size() != 0 || exp1.size() != 0 || !fin3 || !fin1) begin
         fails++;
         $display("FAIL drain pending8=%0d pending3=%0d pending1=%0d required 0",
                  exp8.size(), exp3.size(), exp1.size());
      end
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      int n;
      logic [6:0] v;
      wait (rst_s_n);
      @(posedge clk); #1;
      for (int i = 0; i < 128; i++) begin
         v = 7'(i);
         n = 0;
         while ((busy3 || done3) && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         a3 = v[2:0]; b3 = v[5:3]; cin3 = v[6]; start3 = 1'b1;
         exp3.push_back({1'b0, v[2:0]} + {1'b0, v[5:3]} + {3'd0, v[6]});
         @(posedge clk); #1;
         start3 = 1'b0;
      end
      fin3 = 1'b1;
   end

   initial begin
      int n;
      logic [2:0] v;
      wait (rst_s_n);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         n = 0;
         while ((busy1 || done1) && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         a1 = v[0:0]; b1 = v[1:1]; cin1 = v[2]; start1 = 1'b1;
         exp1.push_back({1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]});
         @(posedge clk); #1;
         start1 = 1'b0;
      end
      fin1 = 1'b1;
   end
endmodule
